// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 codes, FSM state type, pending-load record and
//               the byte-lane mask helper for the load/store alignment unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SPLIT_HI = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] funct3;
        logic [1:0] off;
        logic       split;
    } pend_t;

    function automatic logic f3_is_valid(input logic [2:0] funct3);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // Returns {lanes of W+1, lanes of W}; a non-zero upper nibble means split.
    function automatic logic [7:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = 4'b0000;
        hi = 4'b0000;
        case (funct3)
            F3_LB, F3_LBU: lo = 4'b0001 << off;
            F3_LH, F3_LHU: begin
                if (off == 2'd3) begin
                    lo = 4'b1000;
                    hi = 4'b0001;
                end else begin
                    lo = 4'b0011 << off;
                end
            end
            F3_LW: begin
                lo = 4'b1111 << off;
                hi = ~lo;
            end
            default: ;
        endcase
        return {hi, lo};
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_rotator.sv
// ============================================================================
// Module      : byte_rotator
// Description : 32-bit rotate by whole bytes (8*off), left or right.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_rotator (
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic        i_right,
    output logic [31:0] o_data
);

    // A right rotate by k bytes is a left rotate by (4-k) mod 4 bytes.
    logic [1:0] w_amt;
    assign w_amt = i_right ? (2'd0 - i_off) : i_off;

    always_comb begin
        o_data = i_data;
        case (w_amt)
            2'd1:    o_data = {i_data[23:0], i_data[31:24]};
            2'd2:    o_data = {i_data[15:0], i_data[31:16]};
            2'd3:    o_data = {i_data[7:0],  i_data[31:8]};
            default: o_data = i_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : RV32I load/store alignment between execute and word-addressed
//               dmem; splits word-crossing accesses into two dmem cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter int WADDR_WIDTH = 11,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_read,
    input  logic                   i_write,
    input  logic [2:0]             i_funct3,
    input  logic [31:0]            i_addr,
    input  logic [DATA_WIDTH-1:0]  i_wdata,
    output logic                   o_ready,
    output logic [WADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]  o_mem_wdata,
    output logic                   o_mem_we,
    output logic [3:0]             o_mem_type,
    input  logic [DATA_WIDTH-1:0]  i_mem_rdata,
    output logic                   o_load_valid,
    output logic [DATA_WIDTH-1:0]  o_load_data
);

    state_t                 r_state;
    logic [2:0]             r_funct3;
    logic [1:0]             r_off;
    logic [WADDR_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_write;
    logic [3:0]             r_hi_mask;
    pend_t                  r_pend;
    logic [DATA_WIDTH-1:0]  r_hold;

    logic [1:0]             w_off;
    logic [WADDR_WIDTH-1:0] w_word;
    logic                   w_op;
    logic [7:0]             w_mask;
    logic                   w_split;
    logic [DATA_WIDTH-1:0]  w_wdata_rot;
    logic [DATA_WIDTH-1:0]  w_merged;
    logic [DATA_WIDTH-1:0]  w_rot;
    pend_t                  w_pend_next;
    logic                   w_unused_addr;

    assign w_off         = i_addr[1:0];
    assign w_word        = i_addr[WADDR_WIDTH+1:2];
    assign w_unused_addr = ^i_addr[31:WADDR_WIDTH+2];
    assign w_op          = i_valid & (i_read | i_write) & f3_is_valid(i_funct3);
    assign w_mask        = lane_mask(i_funct3, w_off);
    assign w_split       = w_op & (|w_mask[7:4]);

    byte_rotator u_store_rot (
        .i_data  (i_wdata),
        .i_off   (w_off),
        .i_right (1'b0),
        .o_data  (w_wdata_rot)
    );

    // Request side: reset suppresses any access, including a pending SPLIT_HI.
    always_comb begin
        o_ready     = 1'b1;
        o_mem_addr  = w_word;
        o_mem_wdata = w_wdata_rot;
        o_mem_we    = 1'b0;
        o_mem_type  = 4'b0000;
        w_pend_next = '0;
        if (!i_reset) begin
            if (r_state == SPLIT_HI) begin
                o_mem_addr  = r_word + WADDR_WIDTH'(1);
                o_mem_wdata = r_wdata;
                o_mem_we    = r_write;
                o_mem_type  = r_hi_mask;
                w_pend_next = '{valid: ~r_write, funct3: r_funct3, off: r_off, split: 1'b0};
            end else if (w_op) begin
                o_mem_type  = w_mask[3:0];
                o_mem_we    = i_write;
                o_ready     = ~w_split;
                w_pend_next = '{valid: ~i_write, funct3: i_funct3, off: w_off, split: w_split};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_hold  <= '0;
        end else begin
            r_pend <= w_pend_next;
            // Hold only lives for the one cycle between the two halves of a split load.
            r_hold <= (r_pend.valid & r_pend.split) ? i_mem_rdata : '0;
            case (r_state)
                IDLE: begin
                    if (w_split) begin
                        r_funct3  <= i_funct3;
                        r_off     <= w_off;
                        r_word    <= w_word;
                        r_wdata   <= w_wdata_rot;
                        r_write   <= i_write;
                        r_hi_mask <= w_mask[7:4];
                        r_state   <= SPLIT_HI;
                    end
                end
                SPLIT_HI: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    assign w_merged = r_hold | i_mem_rdata;

    byte_rotator u_load_rot (
        .i_data  (w_merged),
        .i_off   (r_pend.off),
        .i_right (1'b1),
        .o_data  (w_rot)
    );

    assign o_load_valid = r_pend.valid & ~r_pend.split & ~i_reset;

    always_comb begin
        case (r_pend.funct3)
            F3_LB:   o_load_data = {{24{w_rot[7]}},  w_rot[7:0]};
            F3_LH:   o_load_data = {{16{w_rot[15]}}, w_rot[15:0]};
            F3_LBU:  o_load_data = {24'h000000, w_rot[7:0]};
            F3_LHU:  o_load_data = {16'h0000,   w_rot[15:0]};
            default: o_load_data = w_rot;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
// ============================================================================
// Module      : tb_lsu_align
// Description : Self-checking bench for lsu_align with a byte-addressed
//               reference memory and a word-addressed dmem model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_align;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        ready;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_type;
    logic [31:0] mem_rdata = 32'h0;
    logic        load_valid;
    logic [31:0] load_data;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [7:0]  ref_mem [0:8191];
    logic [31:0] dmem    [0:2047];
    logic        init_mem = 1'b0;
    logic [10:0] init_ptr = 11'h0;
    logic        sb_on    = 1'b0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    lsu_align #(.WADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_valid      (valid),
        .i_read       (rd),
        .i_write      (wr),
        .i_funct3     (f3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_ready      (ready),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we),
        .o_mem_type   (mem_type),
        .i_mem_rdata  (mem_rdata),
        .o_load_valid (load_valid),
        .o_load_data  (load_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // dmem: registered read, unselected lanes zero; one word per cycle during init.
    always @(posedge clk) begin
        if (init_mem) begin
            dmem[init_ptr] <= {ref_mem[4*int'(init_ptr)+3], ref_mem[4*int'(init_ptr)+2],
                               ref_mem[4*int'(init_ptr)+1], ref_mem[4*int'(init_ptr)]};
            init_ptr <= init_ptr + 11'd1;
        end else if (mem_we) begin
            dmem[mem_addr] <= (dmem[mem_addr] & ~lanes(mem_type)) | (mem_wdata & lanes(mem_type));
        end
        mem_rdata <= mem_we ? 32'h0 : (dmem[mem_addr] & lanes(mem_type));
    end

    function automatic int size_of(input logic [2:0] ff);
        return (ff[1:0] == 2'b00) ? 1 : (ff[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] ff, input logic [31:0] a);
        int          sz;
        int          base;
        logic [31:0] v;
        sz   = size_of(ff);
        base = int'(a[12:0]);
        v    = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(base + i) % 8192];
        if (!ff[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!ff[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] ff, input logic [31:0] a, input logic [31:0] d);
        int base;
        base = int'(a[12:0]);
        for (int i = 0; i < size_of(ff); i++) ref_mem[(base + i) % 8192] = d[8*i +: 8];
    endtask

    task automatic put_word(input int w, input logic [31:0] val);
        for (int b = 0; b < 4; b++) ref_mem[4*w + b] = val[8*b +: 8];
    endtask

    task automatic set_op(input logic v, input logic r, input logic w, input logic [2:0] ff,
                          input logic [31:0] a, input logic [31:0] d);
        valid = v; rd = r; wr = w; f3 = ff; addr = a; wdata = d;
    endtask

    task automatic op_idle();
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'($urandom);
        put_word(32'h10,  32'h44332211);
        put_word(32'h11,  32'h88776655);
        put_word(32'h7FF, 32'hA1B2C3D4);
        put_word(32'h000, 32'h5E6F7081);
        op_idle();
        init_mem = 1'b1;
        repeat (2048) @(posedge clk);
        #1;
        init_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(1'b1, 1'b1, 1'b0, F3_LW, 32'h42, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_type, mem_we, ready, load_valid} !== 7'b0000_0_1_0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {mem_type, mem_we, ready, load_valid}, 7'b0000010);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        op_idle();
        @(negedge clk);
        checks++;
        if (load_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_load got=%b exp=0", load_valid);
        end
        step();
    endtask

    task automatic test_aligned_load();
        set_op(1'b1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_type, mem_we, ready} !== {11'h010, 4'b1111, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL lw_req got=%h exp=%h", {mem_addr, mem_type, mem_we, ready}, {11'h010, 4'b1111, 1'b0, 1'b1});
        end
        step();
        op_idle();
        @(negedge clk);
        checks++;
        if ({load_valid, load_data} !== {1'b1, 32'h44332211}) begin
            failures++;
            $display("FAIL lw_data got=%b/%h exp=1/44332211", load_valid, load_data);
        end
        step();
    endtask

    task automatic test_byte_loads();
        logic [31:0] ta [3];
        logic [2:0]  tf [3];
        logic [10:0] tw [3];
        logic [31:0] td [3];
        ta = '{32'h43, 32'h47, 32'h47};
        tf = '{F3_LB, F3_LB, F3_LBU};
        tw = '{11'h010, 11'h011, 11'h011};
        td = '{32'h00000044, 32'hFFFFFF88, 32'h00000088};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_op(1'b1, 1'b1, 1'b0, tf[i], ta[i], 32'h0);
            else op_idle();
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if ({mem_addr, mem_type, ready} !== {tw[i], 4'b1000, 1'b1}) begin
                    failures++;
                    $display("FAIL byte_req%0d got=%h exp=%h", i, {mem_addr, mem_type, ready}, {tw[i], 4'b1000, 1'b1});
                end
            end
            if (i > 0) begin
                checks++;
                if ({load_valid, load_data} !== {1'b1, td[i-1]}) begin
                    failures++;
                    $display("FAIL byte_data%0d got=%b/%h exp=1/%h", i - 1, load_valid, load_data, td[i-1]);
                end
            end
            step();
        end
    endtask

    task automatic test_split_load();
        set_op(1'b1, 1'b1, 1'b0, F3_LW, 32'h42, 32'h0);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_type, mem_we, ready, load_valid} !== {11'h010, 4'b1100, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL split_lo got=%h exp=%h", {mem_addr, mem_type, mem_we, ready, load_valid}, {11'h010, 4'b1100, 3'b000});
        end
        step();
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_type, mem_we, ready, load_valid} !== {11'h011, 4'b0011, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL split_hi got=%h exp=%h", {mem_addr, mem_type, mem_we, ready, load_valid}, {11'h011, 4'b0011, 3'b010});
        end
        step();
        op_idle();
        @(negedge clk);
        checks++;
        if ({load_valid, load_data} !== {1'b1, 32'h66554433}) begin
            failures++;
            $display("FAIL split_data got=%b/%h exp=1/66554433", load_valid, load_data);
        end
        step();
    endtask

    task automatic test_split_store();
        set_op(1'b1, 1'b0, 1'b1, F3_LH, 32'h43, 32'h0000BEEF);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_type, mem_we, ready, mem_wdata} !== {11'h010, 4'b1000, 1'b1, 1'b0, 32'hEF0000BE}) begin
            failures++;
            $display("FAIL sh_lo got=%h exp=%h", {mem_addr, mem_type, mem_we, ready, mem_wdata}, {11'h010, 4'b1000, 1'b1, 1'b0, 32'hEF0000BE});
        end
        step();
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_type, mem_we, ready, mem_wdata} !== {11'h011, 4'b0001, 1'b1, 1'b1, 32'hEF0000BE}) begin
            failures++;
            $display("FAIL sh_hi got=%h exp=%h", {mem_addr, mem_type, mem_we, ready, mem_wdata}, {11'h011, 4'b0001, 1'b1, 1'b1, 32'hEF0000BE});
        end
        step();
        set_op(1'b1, 1'b1, 1'b0, F3_LHU, 32'h43, 32'h0);
        @(negedge clk);
        checks++;
        if ({load_valid, ready, mem_type} !== {1'b0, 1'b0, 4'b1000}) begin
            failures++;
            $display("FAIL lhu_lo got=%b exp=%b", {load_valid, ready, mem_type}, 6'b001000);
        end
        step();
        @(negedge clk);
        checks++;
        if ({ready, mem_type} !== {1'b1, 4'b0001}) begin
            failures++;
            $display("FAIL lhu_hi got=%b exp=%b", {ready, mem_type}, 5'b10001);
        end
        step();
        set_op(1'b1, 1'b1, 1'b0, F3_LH, 32'h43, 32'h0);
        @(negedge clk);
        checks++;
        if ({load_valid, load_data, ready} !== {1'b1, 32'h0000BEEF, 1'b0}) begin
            failures++;
            $display("FAIL lhu_data got=%b/%h/%b exp=1/0000beef/0", load_valid, load_data, ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL lh_hi_ready got=%b exp=1", ready);
        end
        step();
        op_idle();
        @(negedge clk);
        checks++;
        if ({load_valid, load_data} !== {1'b1, 32'hFFFFBEEF}) begin
            failures++;
            $display("FAIL lh_data got=%b/%h exp=1/ffffbeef", load_valid, load_data);
        end
        step();
    endtask

    task automatic test_wrap();
        set_op(1'b1, 1'b1, 1'b0, F3_LW, 32'hABCDFFFD, 32'h0);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_type, ready} !== {11'h7FF, 4'b1110, 1'b0}) begin
            failures++;
            $display("FAIL wrap_lo got=%h exp=%h", {mem_addr, mem_type, ready}, {11'h7FF, 4'b1110, 1'b0});
        end
        step();
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_type, ready} !== {11'h000, 4'b0001, 1'b1}) begin
            failures++;
            $display("FAIL wrap_hi got=%h exp=%h", {mem_addr, mem_type, ready}, {11'h000, 4'b0001, 1'b1});
        end
        step();
        op_idle();
        @(negedge clk);
        checks++;
        if ({load_valid, load_data} !== {1'b1, 32'h81A1B2C3}) begin
            failures++;
            $display("FAIL wrap_data got=%b/%h exp=1/81a1b2c3", load_valid, load_data);
        end
        step();
    endtask

    task automatic test_reset_split();
        set_op(1'b1, 1'b1, 1'b0, F3_LW, 32'h42, 32'h0);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL rsplit_stall got=%b exp=0", ready);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_type, mem_we, load_valid} !== 6'b000000) begin
            failures++;
            $display("FAIL rsplit_during got=%b exp=000000", {mem_type, mem_we, load_valid});
        end
        step();
        rst = 1'b0;
        op_idle();
        @(negedge clk);
        checks++;
        if ({mem_type, mem_we, ready, load_valid} !== 7'b0000_0_1_0) begin
            failures++;
            $display("FAIL rsplit_after got=%b exp=0000010", {mem_type, mem_we, ready, load_valid});
        end
        step();
        @(negedge clk);
        checks++;
        if (load_valid !== 1'b0) begin
            failures++;
            $display("FAIL rsplit_noresult got=%b exp=0", load_valid);
        end
        step();
    endtask

    task automatic test_invalid();
        logic [2:0] ff [3];
        logic [1:0] rw [3];
        ff = '{3'b011, F3_LW, 3'b111};
        rw = '{2'b10, 2'b00, 2'b01};
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, rw[i][1], rw[i][0], ff[i], 32'h40, 32'hDEADBEEF);
            @(negedge clk);
            checks++;
            if ({mem_type, mem_we, ready} !== 6'b0000_0_1) begin
                failures++;
                $display("FAIL invalid%0d_req got=%b exp=000001", i, {mem_type, mem_we, ready});
            end
            step();
            op_idle();
            @(negedge clk);
            checks++;
            if (load_valid !== 1'b0) begin
                failures++;
                $display("FAIL invalid%0d_load got=%b exp=0", i, load_valid);
            end
            step();
        end
    endtask

    // Scoreboard: every load result must appear exactly one cycle after acceptance.
    always @(negedge clk) begin
        if (sb_on) begin
            if (load_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_load_unexpected got=%h exp=none", load_data);
                end else begin
                    e = sb.pop_front();
                    if (load_data !== e.data || cycle != e.cyc) begin
                        failures++;
                        $display("FAIL rnd_load got=%h@%0d exp=%h@%0d", load_data, cycle, e.data, e.cyc);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cycle) begin
                checks++;
                failures++;
                $display("FAIL rnd_load_missing got=none exp=%h@%0d", sb[0].data, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic test_random(input int n);
        logic        v, r, w, meaningful, split, accepted;
        logic [2:0]  ff;
        logic [31:0] a, d;
        int          sz;
        sb_on = 1'b1;
        for (int k = 0; k < n; k++) begin
            v = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 5))
                0, 1, 2: {r, w} = 2'b10;
                3, 4:    {r, w} = 2'b01;
                default: {r, w} = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            endcase
            ff = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 2))
                0:       a[12:0] = 13'h1FF0 | 13'($urandom_range(0, 15));
                1:       a[12:0] = 13'($urandom_range(0, 15));
                default: a[12:0] = 13'h0040 | 13'($urandom_range(0, 15));
            endcase
            d  = $urandom;
            sz = size_of(ff);
            meaningful = v && (r || w) && (ff inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
            split = meaningful && ((sz == 2 && a[1:0] == 2'd3) || (sz == 4 && a[1:0] != 2'd0));
            set_op(v, r, w, ff, a, d);
            accepted = 1'b0;
            for (int c = 0; c < 3 && !accepted; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    checks++;
                    if (ready !== !split) begin
                        failures++;
                        $display("FAIL rnd_ready op%0d got=%b exp=%b", k, ready, !split);
                    end
                    if (!meaningful) begin
                        checks++;
                        if ({mem_type, mem_we} !== 5'b00000) begin
                            failures++;
                            $display("FAIL rnd_noop op%0d got=%b exp=00000", k, {mem_type, mem_we});
                        end
                    end
                end
                if (ready === 1'b1) begin
                    accepted = 1'b1;
                    if (meaningful) begin
                        if (w) ref_store(ff, a, d);
                        else sb.push_back('{ref_load(ff, a), cycle + 1});
                    end
                end
                step();
            end
            if (!accepted) begin
                checks++;
                failures++;
                $display("FAIL rnd_timeout op%0d got=not_ready exp=ready", k);
            end
            if ($urandom_range(0, 3) == 0) begin
                op_idle();
                step();
            end
        end
        op_idle();
        repeat (4) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rnd_leftover got=%0d exp=0", sb.size());
        end
        sb_on = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        op_idle();
        test_reset();
        preload();
        test_aligned_load();
        test_byte_loads();
        test_split_load();
        test_split_store();
        test_wrap();
        test_reset_split();
        test_invalid();
        preload();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the execute stage and the word-addressed data memory (dmem). Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word address, byte-lane enables and lane-rotated write data. On the return path it extracts and sign- or zero-extends load data. Misaligned halfword and word accesses that cross a word boundary are split into two consecutive dmem accesses, and upstream is stalled for one cycle while this happens.

## Interface
- WADDR_WIDTH, 11: dmem word-address width (DEPTH 2048).
- DATA_WIDTH, 32: data width; 4 byte lanes.

- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  memory op presented by execute stage
- i_read  in  1  op is a load
- i_write  in  1  op is a store; wins if both i_read and i_write are set
- i_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-justified
- o_ready  out  1  op accepted this cycle; low = upstream holds its inputs
- o_mem_addr  out  WADDR_WIDTH  dmem word address
- o_mem_wdata  out  32  lane-rotated write data
- o_mem_we  out  1  dmem write enable
- o_mem_type  out  4  dmem byte-lane enables
- i_mem_rdata  in  32  dmem read data, registered, unselected lanes zero
- o_load_valid  out  1  load result valid this cycle
- o_load_data  out  32  extended load result

## Operation
- off = i_addr[1:0]; word W = i_addr[WADDR_WIDTH+1:2]; W+1 wraps modulo 2^WADDR_WIDTH.
- Lane masks:
  - B: lane off.
  - H: lanes off and off+1. If off==3, split: lane 3 of W, then lane 0 of W+1.
  - W with off==0: 1111.
  - W with off!=0: split: lanes off..3 of W, then lanes 0..off-1 of W+1.
- Write data is i_wdata rotated left by 8*off. The same rotated value is driven on both halves of a split store.
- Load merge: low-half hold register OR i_mem_rdata. Lane sets are disjoint because dmem zeroes unselected lanes. The merged word is rotated right by 8*off, then:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- Invalid funct3 (011, 110, 111), or i_valid with neither i_read nor i_write:
  - o_mem_type=0, o_mem_we=0.
  - No load_valid.
  - o_ready=1.
- With no op, o_mem_type=0 and o_mem_we=0. o_mem_addr follows i_addr, value don't-care.
- FSM states:
  - IDLE, non-split valid op: o_ready=1, stay in IDLE.
  - IDLE, split op: o_ready=0; latch funct3, off, W, rotated wdata and read/write; go to SPLIT_HI.
  - SPLIT_HI: issue W+1 from the latched values (current inputs ignored), o_ready=1, go to IDLE.
- A load-pending pipeline register (valid, funct3, off, split flag) tracks each issued load access.

## Timing
- Request outputs (o_mem_*, o_ready) are combinational from inputs and state, in the issue cycle.
- Aligned load accepted in cycle N: o_load_valid=1 with o_load_data in N+1, combinational from i_mem_rdata and the pending register.
- Split load:
  - N: access W, o_ready=0.
  - N+1: access W+1, o_ready=1; low-half i_mem_rdata captured into the hold register.
  - N+2: o_load_valid=1, merged result.
- Split store: lower lanes of W written in N, upper lanes of W+1 in N+1. No load_valid.
- Back-to-back ops have no bubble beyond the split stall. A new op in N+2 overlaps the previous result cycle without conflict.
- Reset (takes effect at the clock edge):
  - state = IDLE, pending load valid = 0, hold register = 0.
  - o_load_valid=0, o_ready=1, o_mem_type=0, o_mem_we=0.
  - Reset during SPLIT_HI: the second access is not issued and no load result is produced.

## Structure
- Package lsu_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - state enum {IDLE, SPLIT_HI}.
  - lane-mask function.
- Sub-module byte_rotator: 32-bit rotate by 8*off, with a direction input. Instantiated twice: store rotate-left, load rotate-right.

## Test plan
Memory preload: word 0x10 = 0x44332211, word 0x11 = 0x88776655.
- LW 0x40 → N: addr 0x10, type 1111 → N+1: load_valid=1, data 0x44332211.
- LB 0x43 → type 1000, data 0x00000044. LB 0x47 → 0xFFFFFF88. LBU 0x47 → 0x00000088.
- LW 0x42:
  - N: addr 0x10, type 1100, o_ready=0.
  - N+1: addr 0x11, type 0011, o_ready=1.
  - N+2: data 0x66554433.
- SH 0x43, wdata 0x0000BEEF:
  - N: addr 0x10, type 1000, we=1, wdata 0xEF0000BE.
  - N+1: addr 0x11, type 0001.
  - Then LHU 0x43 → 0x0000BEEF; LH 0x43 → 0xFFFFBEEF.
- Split LW at word 0x7FF (byte 0x1FFD) → second access to word 0x000 (wrap).
- i_reset asserted in SPLIT_HI → next cycle type 0, we 0, o_ready 1, no load_valid. Separately, funct3 011 with i_read → type 0, no load_valid.
